reg_bank_seq: RTL and testbench

- Sequencer that drives the 3-register bank (reg0/reg1 operands, reg2 result) and the ALU for one two-operand operation at a time.
- Accepts {a, b, op} on a valid/ready request port, then:
  - writes a to reg0 and b to reg1;
  - issues the operand read;
  - waits for the ALU;
  - reads reg2 back;
  - returns the result on a valid/ready response port.
- Sits between instruction decode and register bank/ALU. It is the only master of the bank control pins.

---
 rtl/reg_bank_seq_pkg.sv | 18 +
 rtl/reg_bank_seq_if.sv | 28 ++
 rtl/reg_bank_seq.sv | 180 ++++++++++++++++++
 tb/tb_reg_bank_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_seq_pkg.sv
// Shared definitions for the register-bank sequencer: default widths, ALU opcodes, FSM state encoding.
package reg_bank_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned OP_W_DEF   = 3;
   localparam int unsigned CNT_W      = 4;

   localparam int unsigned OP_ADD = 0;
   localparam int unsigned OP_SUB = 1;
   localparam int unsigned OP_AND = 2;
   localparam int unsigned OP_OR  = 3;
   localparam int unsigned OP_XOR = 4;

   typedef enum logic [3:0] {
      INIT, IDLE, CLR, WR_A, WR_B, RD_OP, EXEC, RD_RES, CAPT, DONE
   } state_t;

endpackage

// File: rtl/reg_bank_seq_if.sv
// Request/response handshake bundle between instruction decode (master) and the sequencer (slave).
interface reg_bank_seq_if
   import reg_bank_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned OP_W   = OP_W_DEF
) ();

   logic              ctrl_req_valid;
   logic              ctrl_req_ready;
   logic [DATA_W-1:0] ctrl_req_a;
   logic [DATA_W-1:0] ctrl_req_b;
   logic [OP_W-1:0]   ctrl_req_op;
   logic              ctrl_res_valid;
   logic              ctrl_res_ready;
   logic [DATA_W-1:0] ctrl_res_data;

   modport master (
      output ctrl_req_valid, ctrl_req_a, ctrl_req_b, ctrl_req_op, ctrl_res_ready,
      input  ctrl_req_ready, ctrl_res_valid, ctrl_res_data
   );

   modport slave (
      input  ctrl_req_valid, ctrl_req_a, ctrl_req_b, ctrl_req_op, ctrl_res_ready,
      output ctrl_req_ready, ctrl_res_valid, ctrl_res_data
   );

endinterface

// File: rtl/reg_bank_seq.sv
// Sequencer driving the 3-register bank and ALU for one two-operand operation at a time.
// Optional REG_BANK_SEQ_OPCNT_EN adds a 16-bit completed-operation counter output.
module reg_bank_seq
   import reg_bank_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned OP_W    = OP_W_DEF,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic              ctrl_clk,
   input  logic              ctrl_rst_n,
   reg_bank_seq_if.slave     ctrl_if,
   input  logic              ctrl_clr_req,
   output logic              ctrl_busy,
   output logic              ctrl_bank_rst,
   output logic [DATA_W-1:0] ctrl_bank_data_in,
   output logic              ctrl_bank_sel,
   output logic              ctrl_bank_we,
   output logic              ctrl_bank_re,
   input  logic [DATA_W-1:0] ctrl_bank_data_out2,
   output logic [OP_W-1:0]   ctrl_alu_op
`ifdef REG_BANK_SEQ_OPCNT_EN
   ,
   output logic [15:0]       ctrl_op_count
`endif
);

   state_t            r_state, w_state_nxt;
   logic [DATA_W-1:0] r_a, r_b, r_result, w_a_nxt, w_b_nxt, w_result_nxt;
   logic [OP_W-1:0]   r_op, w_op_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

   logic              r_busy, r_bank_rst, r_sel, r_we, r_re, r_res_valid;
   logic              w_busy, w_bank_rst, w_sel, w_we, w_re, w_res_valid;
   logic [DATA_W-1:0] r_data_in, r_res_data, w_data_in, w_res_data;
   logic [OP_W-1:0]   r_alu_op, w_alu_op;

   // Next state and datapath, then outputs decoded from the next state so they align with it.
   always_comb begin
      w_state_nxt  = r_state;
      w_a_nxt      = r_a;
      w_b_nxt      = r_b;
      w_op_nxt     = r_op;
      w_cnt_nxt    = r_cnt;
      w_result_nxt = r_result;

      case (r_state)
         INIT:    if (r_bank_rst) w_state_nxt = IDLE;
         IDLE: begin
            if (ctrl_clr_req) begin
               w_state_nxt = CLR;
            end else if (ctrl_if.ctrl_req_valid) begin
               w_a_nxt     = ctrl_if.ctrl_req_a;
               w_b_nxt     = ctrl_if.ctrl_req_b;
               w_op_nxt    = ctrl_if.ctrl_req_op;
               w_state_nxt = WR_A;
            end
         end
         CLR:     w_state_nxt = IDLE;
         WR_A:    w_state_nxt = WR_B;
         WR_B:    w_state_nxt = RD_OP;
         RD_OP: begin
            w_cnt_nxt   = CNT_W'(ALU_LAT - 1);
            w_state_nxt = EXEC;
         end
         EXEC: begin
            if (r_cnt == '0) w_state_nxt = RD_RES;
            else             w_cnt_nxt   = r_cnt - CNT_W'(1);
         end
         RD_RES:  w_state_nxt = CAPT;
         CAPT: begin
            w_result_nxt = ctrl_bank_data_out2;
            w_state_nxt  = DONE;
         end
         DONE:    if (ctrl_if.ctrl_res_ready) w_state_nxt = IDLE;
         default: w_state_nxt = INIT;
      endcase

      w_busy      = (w_state_nxt != IDLE);
      w_bank_rst  = 1'b0;
      w_data_in   = '0;
      w_sel       = 1'b0;
      w_we        = 1'b0;
      w_re        = 1'b0;
      w_alu_op    = '0;
      w_res_valid = 1'b0;
      w_res_data  = '0;

      case (w_state_nxt)
         INIT, CLR: w_bank_rst = 1'b1;
         WR_A: begin
            w_we      = 1'b1;
            w_data_in = w_a_nxt;
            w_alu_op  = w_op_nxt;
         end
         WR_B: begin
            w_we      = 1'b1;
            w_sel     = 1'b1;
            w_data_in = r_b;
            w_alu_op  = r_op;
         end
         RD_OP: begin
            w_re     = 1'b1;
            w_alu_op = r_op;
         end
         EXEC, CAPT: w_alu_op = r_op;
         RD_RES: begin
            w_re     = 1'b1;
            w_sel    = 1'b1;
            w_alu_op = r_op;
         end
         DONE: begin
            w_res_valid = 1'b1;
            w_res_data  = w_result_nxt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
      if (!ctrl_rst_n) begin
         r_state     <= INIT;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_busy      <= 1'b1;
         r_bank_rst  <= 1'b0;
         r_data_in   <= '0;
         r_sel       <= 1'b0;
         r_we        <= 1'b0;
         r_re        <= 1'b0;
         r_alu_op    <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_a         <= w_a_nxt;
         r_b         <= w_b_nxt;
         r_op        <= w_op_nxt;
         r_cnt       <= w_cnt_nxt;
         r_result    <= w_result_nxt;
         r_busy      <= w_busy;
         r_bank_rst  <= w_bank_rst;
         r_data_in   <= w_data_in;
         r_sel       <= w_sel;
         r_we        <= w_we;
         r_re        <= w_re;
         r_alu_op    <= w_alu_op;
         r_res_valid <= w_res_valid;
         r_res_data  <= w_res_data;
      end
   end

`ifdef REG_BANK_SEQ_OPCNT_EN
   logic [15:0] r_op_count;

   // Counts response handshakes; a bank clear also restarts the count.
   always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
      if (!ctrl_rst_n)                                      r_op_count <= '0;
      else if (w_state_nxt == CLR)                          r_op_count <= '0;
      else if (r_state == DONE && ctrl_if.ctrl_res_ready)   r_op_count <= r_op_count + 16'd1;
   end

   assign ctrl_op_count = r_op_count;
`endif

   assign ctrl_if.ctrl_req_ready = (r_state == IDLE) && !ctrl_clr_req;
   assign ctrl_if.ctrl_res_valid = r_res_valid;
   assign ctrl_if.ctrl_res_data  = r_res_data;
   assign ctrl_busy              = r_busy;
   assign ctrl_bank_rst          = r_bank_rst;
   assign ctrl_bank_data_in      = r_data_in;
   assign ctrl_bank_sel          = r_sel;
   assign ctrl_bank_we           = r_we;
   assign ctrl_bank_re           = r_re;
   assign ctrl_alu_op            = r_alu_op;

endmodule

// File: tb/tb_reg_bank_seq.sv
// Directed bench for reg_bank_seq with a behavioural register bank and ALU attached to the bank pins.
module tb_reg_bank_seq;
   import reg_bank_pkg::*;

`ifdef REG_BANK_SEQ_OPCNT_EN
   localparam int unsigned ALU_LAT = 4;
`else
   localparam int unsigned ALU_LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr_req = 1'b0;
   logic       busy, bank_rst, bank_sel, bank_we, bank_re;
   logic [7:0] bank_din, bank_dout2;
   logic [2:0] alu_op;
`ifdef REG_BANK_SEQ_OPCNT_EN
   logic [15:0] op_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   reg_bank_seq_if #(.DATA_W(8), .OP_W(3)) ctrl_if ();

   reg_bank_seq #(.DATA_W(8), .OP_W(3), .ALU_LAT(ALU_LAT)) dut (
      .ctrl_clk           (clk),
      .ctrl_rst_n         (rst_n),
      .ctrl_if            (ctrl_if),
      .ctrl_clr_req       (clr_req),
      .ctrl_busy          (busy),
      .ctrl_bank_rst      (bank_rst),
      .ctrl_bank_data_in  (bank_din),
      .ctrl_bank_sel      (bank_sel),
      .ctrl_bank_we       (bank_we),
      .ctrl_bank_re       (bank_re),
      .ctrl_bank_data_out2(bank_dout2),
      .ctrl_alu_op        (alu_op)
`ifdef REG_BANK_SEQ_OPCNT_EN
      ,
      .ctrl_op_count      (op_count)
`endif
   );

   always #5 clk = ~clk;

   // Bank and ALU model: operands latched on read, reg2 samples the ALU every edge.
   logic [7:0] m_reg0, m_reg1, m_reg2, m_out0, m_out1, m_out2;

   function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         default: return 8'h00;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (bank_rst) begin
         m_reg0 <= '0; m_reg1 <= '0; m_reg2 <= '0;
         m_out0 <= '0; m_out1 <= '0; m_out2 <= '0;
      end else begin
         if (bank_we && !bank_sel) m_reg0 <= bank_din;
         if (bank_we &&  bank_sel) m_reg1 <= bank_din;
         if (bank_re && !bank_sel) begin
            m_out0 <= m_reg0;
            m_out1 <= m_reg1;
         end
         if (bank_re && bank_sel) m_out2 <= m_reg2;
         m_reg2 <= alu(m_out0, m_out1, alu_op);
      end
   end
   assign bank_dout2 = m_out2;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [2:0]  op;
      logic [7:0]  exp;
      int unsigned hold;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One full operation: accept, latency, optional backpressure, response handshake.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [7:0] exp, input int unsigned hold);
      int cnt;
      ctrl_if.ctrl_req_valid = 1'b1;
      ctrl_if.ctrl_req_a     = a;
      ctrl_if.ctrl_req_b     = b;
      ctrl_if.ctrl_req_op    = op;
      #1;
      cnt = 0;
      while (!ctrl_if.ctrl_req_ready && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("accept_wait", 32'(cnt), 32'd0);
      tick();
      ctrl_if.ctrl_req_valid = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
      cnt = 0;
      while (!ctrl_if.ctrl_res_valid && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("latency", 32'(cnt), 32'(ALU_LAT + 5));
      chk("res_data", 32'(ctrl_if.ctrl_res_data), 32'(exp));
      for (int i = 0; i < int'(hold); i++) begin
         tick();
         chk("hold_valid", 32'(ctrl_if.ctrl_res_valid), 32'd1);
         chk("hold_data", 32'(ctrl_if.ctrl_res_data), 32'(exp));
         chk("hold_not_ready", 32'(ctrl_if.ctrl_req_ready), 32'd0);
      end
      ctrl_if.ctrl_res_ready = 1'b1;
      tick();
      ctrl_if.ctrl_res_ready = 1'b0;
      chk("res_valid_drop", 32'(ctrl_if.ctrl_res_valid), 32'd0);
      chk("idle_ready", 32'(ctrl_if.ctrl_req_ready), 32'd1);
   endtask

   initial begin
      int stale;
      vecs[0] = '{a: 8'h80, b: 8'h80, op: 3'(OP_ADD), exp: 8'h00, hold: 0};
      vecs[1] = '{a: 8'h55, b: 8'h0F, op: 3'(OP_AND), exp: 8'h05, hold: 10};
      vecs[2] = '{a: 8'hA0, b: 8'h0A, op: 3'(OP_OR),  exp: 8'hAA, hold: 0};
      vecs[3] = '{a: 8'hFF, b: 8'h0F, op: 3'(OP_XOR), exp: 8'hF0, hold: 0};
      vecs[4] = '{a: 8'h10, b: 8'h20, op: 3'(OP_SUB), exp: 8'hF0, hold: 2};
      vecs[5] = '{a: 8'h03, b: 8'h01, op: 3'(OP_ADD), exp: 8'h04, hold: 0};

      ctrl_if.ctrl_req_valid = 1'b0;
      ctrl_if.ctrl_req_a     = '0;
      ctrl_if.ctrl_req_b     = '0;
      ctrl_if.ctrl_req_op    = '0;
      ctrl_if.ctrl_res_ready = 1'b0;

      // Reset values, then the INIT bank clear.
      tick();
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_outs", 32'({bank_rst, bank_we, bank_re, bank_sel, bank_din, alu_op}), 32'd0);
      chk("rst_hs", 32'({ctrl_if.ctrl_req_ready, ctrl_if.ctrl_res_valid, ctrl_if.ctrl_res_data}), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("init_bank_rst", 32'(bank_rst), 32'd1);
      chk("init_not_ready", 32'(ctrl_if.ctrl_req_ready), 32'd0);
      tick();
      chk("init_rst_done", 32'(bank_rst), 32'd0);
      chk("init_ready", 32'(ctrl_if.ctrl_req_ready), 32'd1);
      chk("init_idle", 32'(busy), 32'd0);

      // Single add with bank pin trace.
      ctrl_if.ctrl_req_valid = 1'b1;
      ctrl_if.ctrl_req_a     = 8'h12;
      ctrl_if.ctrl_req_b     = 8'h34;
      ctrl_if.ctrl_req_op    = 3'(OP_ADD);
      tick();
      ctrl_if.ctrl_req_valid = 1'b0;
      chk("wra_ctl", 32'({bank_we, bank_re, bank_sel}), 32'b100);
      chk("wra_din", 32'(bank_din), 32'h12);
      tick();
      chk("wrb_ctl", 32'({bank_we, bank_re, bank_sel}), 32'b101);
      chk("wrb_din", 32'(bank_din), 32'h34);
      tick();
      chk("rdop_ctl", 32'({bank_we, bank_re, bank_sel}), 32'b010);
      chk("rdop_din", 32'(bank_din), 32'h00);
      for (int i = 0; i < int'(ALU_LAT); i++) begin
         tick();
         chk("exec_ctl", 32'({bank_rst, bank_we, bank_re, bank_sel}), 32'd0);
      end
      tick();
      chk("rdres_ctl", 32'({bank_we, bank_re, bank_sel}), 32'b011);
      tick();
      chk("capt_ctl", 32'({bank_we, bank_re, bank_sel, ctrl_if.ctrl_res_valid}), 32'd0);
      tick();
      chk("done_valid", 32'(ctrl_if.ctrl_res_valid), 32'd1);
      chk("done_data", 32'(ctrl_if.ctrl_res_data), 32'h46);
      chk("done_alu_op", 32'(alu_op), 32'd0);
      ctrl_if.ctrl_res_ready = 1'b1;
      tick();
      ctrl_if.ctrl_res_ready = 1'b0;
      chk("trace_valid_drop", 32'(ctrl_if.ctrl_res_valid), 32'd0);

      for (int i = 0; i < 6; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].hold);

      // Clear wins over a simultaneous request.
      clr_req = 1'b1;
      ctrl_if.ctrl_req_valid = 1'b1;
      ctrl_if.ctrl_req_a     = 8'h77;
      ctrl_if.ctrl_req_b     = 8'h11;
      #1;
      chk("clr_blocks_ready", 32'(ctrl_if.ctrl_req_ready), 32'd0);
      tick();
      clr_req = 1'b0;
      ctrl_if.ctrl_req_valid = 1'b0;
      chk("clr_bank_rst", 32'(bank_rst), 32'd1);
      chk("clr_no_write", 32'(bank_we), 32'd0);
      tick();
      chk("clr_one_pulse", 32'(bank_rst), 32'd0);
      chk("clr_back_idle", 32'(busy), 32'd0);
      run_op(8'hFF, 8'h01, 3'(OP_SUB), 8'hFE, 0);

      // Reset during EXEC.
      ctrl_if.ctrl_req_valid = 1'b1;
      ctrl_if.ctrl_req_a     = 8'h5A;
      ctrl_if.ctrl_req_b     = 8'h21;
      ctrl_if.ctrl_req_op    = 3'(OP_ADD);
      tick();
      ctrl_if.ctrl_req_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("midop_in_exec", 32'({bank_we, bank_re, busy}), 32'b001);
      rst_n = 1'b0;
      #1;
      chk("midop_busy", 32'(busy), 32'd1);
      chk("midop_outs", 32'({bank_rst, bank_we, bank_re, bank_sel, bank_din, alu_op}), 32'd0);
      chk("midop_hs", 32'({ctrl_if.ctrl_req_ready, ctrl_if.ctrl_res_valid, ctrl_if.ctrl_res_data}), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("midop_init_rst", 32'(bank_rst), 32'd1);
      tick();
      chk("midop_bank_clear", 32'({m_reg0, m_reg1}), 32'd0);
      chk("midop_ready", 32'(ctrl_if.ctrl_req_ready), 32'd1);
      stale = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ctrl_if.ctrl_res_valid) stale++;
      end
      chk("midop_no_stale", 32'(stale), 32'd0);

      for (int i = 0; i < 3; i++)
         run_op(vecs[i + 2].a, vecs[i + 2].b, vecs[i + 2].op, vecs[i + 2].exp, 0);
`ifdef REG_BANK_SEQ_OPCNT_EN
      chk("op_count_3", 32'(op_count), 32'd3);
`endif
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      chk("clr2_bank_rst", 32'(bank_rst), 32'd1);
      tick();
`ifdef REG_BANK_SEQ_OPCNT_EN
      chk("op_count_clr", 32'(op_count), 32'd0);
`endif
      run_op(8'h12, 8'h34, 3'(OP_ADD), 8'h46, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
